// File: rtl/uart_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_ctrl
// Purpose  : Parses SOF/ADDR/LEN/payload/CHK frames from a UART receiver and
//            replays the payload as address/data write beats with handshake.
//            Optional inactivity timeout: define UART_FRAME_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module uart_frame_ctrl #(
    parameter int            WL        = 8,
    parameter int            MAX_LEN   = 16,
    parameter logic [WL-1:0] SOF       = 8'hA5,
    parameter int            CLK_FREQ  = 100000000,
    parameter int            BAUD_RATE = 9600
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          rx_vld,
    input  logic          rx_par_err,
    input  logic [WL-1:0] rx_data,
    output logic          wr_vld,
    input  logic          wr_rdy,
    output logic [7:0]    wr_addr,
    output logic [WL-1:0] wr_data,
    output logic          wr_last,
    output logic          busy,
    output logic          err,
    output logic [2:0]    err_code,
    output logic          frame_ok
);

    localparam int            IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [WL-1:0] MAX_LEN_B = WL'(MAX_LEN);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR    = 3'd1,
        LEN     = 3'd2,
        PAYLOAD = 3'd3,
        CHK     = 3'd4,
        DRAIN   = 3'd5
    } state_t;

    state_t        state;
    logic [7:0]    frame_addr;
    logic [7:0]    frame_len;
    logic [WL-1:0] chk_acc;
    logic [7:0]    byte_idx;
    logic [7:0]    beat_idx;
    logic [WL-1:0] buffer [MAX_LEN];

    logic          byte_ev;
    logic          in_frame;
    logic          timeout_hit;
    logic [7:0]    next_beat;

    assign byte_ev   = rx_vld | rx_par_err;
    assign in_frame  = (state == ADDR) || (state == LEN) || (state == PAYLOAD) || (state == CHK);
    assign next_beat = beat_idx + 8'd1;
    assign busy      = (state != IDLE);

    generate
        if (BAUD_RATE <= 0 || CLK_FREQ < BAUD_RATE) begin : g_param_check
            $error("uart_frame_ctrl: CLK_FREQ must be >= BAUD_RATE > 0");
        end
    endgenerate

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int TIMEOUT = 22 * (CLK_FREQ / BAUD_RATE);
    logic [31:0] timer;

    // Timer measures idle clocks since the last byte while a frame is open
    always_ff @(posedge CLK) begin
        if (RST || byte_ev || !in_frame) begin
            timer <= 32'd0;
        end else begin
            timer <= timer + 32'd1;
        end
    end

    assign timeout_hit = in_frame && !byte_ev && (timer == 32'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (state == PAYLOAD && rx_vld && !rx_par_err) begin
            buffer[byte_idx[IW-1:0]] <= rx_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            frame_addr <= 8'd0;
            frame_len  <= 8'd0;
            chk_acc    <= '0;
            byte_idx   <= 8'd0;
            beat_idx   <= 8'd0;
            wr_vld     <= 1'b0;
            wr_addr    <= 8'd0;
            wr_data    <= '0;
            wr_last    <= 1'b0;
            err        <= 1'b0;
            err_code   <= 3'd0;
            frame_ok   <= 1'b0;
        end else begin
            err      <= 1'b0;
            frame_ok <= 1'b0;
            if (timeout_hit) begin
                err      <= 1'b1;
                err_code <= 3'd4;
                state    <= IDLE;
            end else if (in_frame && rx_par_err) begin
                err      <= 1'b1;
                err_code <= 3'd1;
                state    <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (rx_vld && rx_data == SOF) begin
                            state <= ADDR;
                        end
                    end
                    ADDR: begin
                        if (rx_vld) begin
                            frame_addr <= rx_data;
                            chk_acc    <= rx_data;
                            state      <= LEN;
                        end
                    end
                    LEN: begin
                        if (rx_vld) begin
                            if (rx_data == '0 || rx_data > MAX_LEN_B) begin
                                err      <= 1'b1;
                                err_code <= 3'd2;
                                state    <= IDLE;
                            end else begin
                                frame_len <= rx_data;
                                chk_acc   <= chk_acc ^ rx_data;
                                byte_idx  <= 8'd0;
                                state     <= PAYLOAD;
                            end
                        end
                    end
                    PAYLOAD: begin
                        if (rx_vld) begin
                            chk_acc  <= chk_acc ^ rx_data;
                            byte_idx <= byte_idx + 8'd1;
                            if (byte_idx == frame_len - 8'd1) begin
                                state <= CHK;
                            end
                        end
                    end
                    CHK: begin
                        if (rx_vld) begin
                            if (rx_data == chk_acc) begin
                                wr_vld   <= 1'b1;
                                wr_addr  <= frame_addr;
                                wr_data  <= buffer[0];
                                wr_last  <= (frame_len == 8'd1);
                                beat_idx <= 8'd0;
                                state    <= DRAIN;
                            end else begin
                                err      <= 1'b1;
                                err_code <= 3'd3;
                                state    <= IDLE;
                            end
                        end
                    end
                    DRAIN: begin
                        // Bytes arriving while draining are dropped, never stalling the drain
                        if (byte_ev) begin
                            err      <= 1'b1;
                            err_code <= 3'd5;
                        end
                        if (wr_vld && wr_rdy) begin
                            if (wr_last) begin
                                wr_vld   <= 1'b0;
                                wr_last  <= 1'b0;
                                frame_ok <= 1'b1;
                                state    <= IDLE;
                            end else begin
                                beat_idx <= next_beat;
                                wr_addr  <= wr_addr + 8'd1;
                                wr_data  <= buffer[next_beat[IW-1:0]];
                                wr_last  <= (next_beat == frame_len - 8'd1);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_frame_ctrl
// Purpose  : Directed self-checking bench for uart_frame_ctrl.
// Revision : 1.0
// ============================================================================
module tb_uart_frame_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       rx_vld = 1'b0;
    logic       rx_par_err = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       wr_vld;
    logic       wr_rdy = 1'b1;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_last;
    logic       busy;
    logic       err;
    logic [2:0] err_code;
    logic       frame_ok;

    int n_chk  = 0;
    int n_pass = 0;
    int err_cnt = 0;
    int ok_cnt  = 0;
    logic [16:0] beats [$];

    uart_frame_ctrl dut (
        .CLK        (CLK),
        .RST        (RST),
        .rx_vld     (rx_vld),
        .rx_par_err (rx_par_err),
        .rx_data    (rx_data),
        .wr_vld     (wr_vld),
        .wr_rdy     (wr_rdy),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_last    (wr_last),
        .busy       (busy),
        .err        (err),
        .err_code   (err_code),
        .frame_ok   (frame_ok)
    );

    always #5 CLK = ~CLK;

    // Inputs change 2ns after the rising edge, so the falling edge sees settled values
    always @(negedge CLK) begin
        if (wr_vld && wr_rdy) beats.push_back({wr_last, wr_addr, wr_data});
        if (err)      err_cnt++;
        if (frame_ok) ok_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #2;
        end
    endtask

    task automatic send(input logic [7:0] d, input logic par);
        @(posedge CLK);
        #2;
        rx_vld     = ~par;
        rx_par_err = par;
        rx_data    = d;
        @(posedge CLK);
        #2;
        rx_vld     = 1'b0;
        rx_par_err = 1'b0;
    endtask

    task automatic wait_ok(input string tag, input int target);
        int budget;
        budget = 50;
        while (ok_cnt != target && budget > 0) begin
            @(negedge CLK);
            budget--;
        end
        check(tag, ok_cnt, target);
    endtask

    initial begin
        step(3);
        RST = 1'b0;
        check("reset_outputs", {wr_vld, wr_addr, wr_data, wr_last, busy, err, err_code, frame_ok}, 32'd0);

        // Noise and parity errors in IDLE are ignored
        send(8'h33, 1'b0);
        send(8'h00, 1'b1);
        step(1);
        check("idle_noise_busy", busy, 0);
        check("idle_noise_err", err_cnt, 0);

        // Basic two-byte frame, chk = 10^02^11^22 = 21
        send(8'hA5, 0); send(8'h10, 0); send(8'h02, 0);
        send(8'h11, 0); send(8'h22, 0); send(8'h21, 0);
        wait_ok("basic_frame_ok", 1);
        step(1);
        check("basic_nbeats", beats.size(), 2);
        check("basic_beat0", beats[0], {1'b0, 8'h10, 8'h11});
        check("basic_beat1", beats[1], {1'b1, 8'h11, 8'h22});
        check("basic_vld_low", wr_vld, 0);
        check("basic_busy", busy, 0);
        check("basic_no_err", err_cnt, 0);

        // Bad checksum, then a good frame
        send(8'hA5, 0); send(8'h10, 0); send(8'h02, 0);
        send(8'h11, 0); send(8'h22, 0); send(8'h00, 0);
        step(2);
        check("chk_err_cnt", err_cnt, 1);
        check("chk_err_code", err_code, 3);
        check("chk_no_beats", beats.size(), 2);
        check("chk_busy", busy, 0);
        send(8'hA5, 0); send(8'h10, 0); send(8'h02, 0);
        send(8'h11, 0); send(8'h22, 0); send(8'h21, 0);
        wait_ok("recover_frame_ok", 2);
        check("recover_beat0", beats[2], {1'b0, 8'h10, 8'h11});
        check("recover_beat1", beats[3], {1'b1, 8'h11, 8'h22});

        // Length zero and length over maximum
        send(8'hA5, 0); send(8'h10, 0); send(8'h00, 0);
        step(1);
        check("len0_code", err_code, 2);
        check("len0_busy", busy, 0);
        send(8'hA5, 0); send(8'h10, 0); send(8'h11, 0);
        step(1);
        check("len17_cnt", err_cnt, 3);
        check("len17_code", err_code, 2);
        check("len17_busy", busy, 0);

        // Backpressure, overrun while draining, address wrap. chk = FE^03^AA^BB^CC = 20
        wr_rdy = 1'b0;
        send(8'hA5, 0); send(8'hFE, 0); send(8'h03, 0);
        send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0); send(8'h20, 0);
        for (int i = 0; i < 3; i++) begin
            check("stall_hold", {wr_vld, wr_addr, wr_data, wr_last}, {1'b1, 8'hFE, 8'hAA, 1'b0});
            step(1);
        end
        send(8'h55, 0);
        step(1);
        check("overrun_code", err_code, 5);
        check("overrun_cnt", err_cnt, 4);
        check("overrun_hold", {wr_vld, wr_addr, wr_data, busy}, {1'b1, 8'hFE, 8'hAA, 1'b1});
        wr_rdy = 1'b1;
        wait_ok("wrap_frame_ok", 3);
        step(1);
        check("wrap_nbeats", beats.size(), 7);
        check("wrap_beat0", beats[4], {1'b0, 8'hFE, 8'hAA});
        check("wrap_beat1", beats[5], {1'b0, 8'hFF, 8'hBB});
        check("wrap_beat2", beats[6], {1'b1, 8'h00, 8'hCC});
        check("wrap_vld_low", wr_vld, 0);

        // Parity error mid-payload
        send(8'hA5, 0); send(8'h10, 0); send(8'h02, 0);
        send(8'h11, 0); send(8'h00, 1);
        step(1);
        check("par_code", err_code, 1);
        check("par_cnt", err_cnt, 5);
        check("par_busy", busy, 0);

`ifndef UART_FRAME_TIMEOUT_EN
        // Without the timeout feature a stalled frame waits forever
        send(8'hA5, 0); send(8'h20, 0);
        step(300);
        check("stall_no_timeout_busy", busy, 1);
        check("stall_no_timeout_err", err_cnt, 5);
`endif

        // Reset abandons any frame without signalling an error
        RST = 1'b1;
        step(1);
        RST = 1'b0;
        step(1);
        check("reset_mid_busy", busy, 0);
        check("reset_mid_code", err_code, 0);
        check("reset_mid_errcnt", err_cnt, 5);
        check("reset_mid_beats", beats.size(), 7);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_frame_ctrl.md
UART_FRAME_CTRL -- requirements
Module: uart_frame_ctrl

Interface
REQ-001 SHALL have parameter WL, 8, byte width (fixed at 8).
REQ-002 SHALL have parameter MAX_LEN, 16, maximum payload bytes per frame.
REQ-003 SHALL have parameter SOF, 8'hA5, start-of-frame byte.
REQ-004 SHALL have parameter CLK_FREQ, 100000000, clock frequency in Hz.
REQ-005 SHALL have parameter BAUD_RATE, 9600, line rate; TIMEOUT = 22*(CLK_FREQ/BAUD_RATE) clocks.
REQ-006 SHALL have port CLK  input  1  single clock; all logic on rising edge.
REQ-007 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port rx_vld  input  1  one-cycle pulse: good byte from UART receiver.
REQ-009 SHALL have port rx_par_err  input  1  one-cycle pulse: byte received with parity error.
REQ-010 SHALL have port rx_data  input  WL  received byte, valid with rx_vld.
REQ-011 SHALL have port wr_vld  output  1  write beat valid.
REQ-012 SHALL have port wr_rdy  input  1  sink accepts beat when wr_vld&&wr_rdy.
REQ-013 SHALL have ports wr_addr/wr_data  output  8/WL  beat address/data; wr_last  output  1  final beat.
REQ-014 SHALL have port busy  output  1  high when state != IDLE.
REQ-015 SHALL have ports err  output  1  one-cycle error pulse; err_code  output  3  cause, held until next err.
REQ-016 SHALL have port frame_ok  output  1  one-cycle pulse on acceptance of final beat.

Function
REQ-017 Byte event = rx_vld or rx_par_err in a cycle; at most one per cycle; rx_par_err takes precedence if both.
REQ-018 Frame: SOF, ADDR, LEN, LEN payload bytes, CHK; CHK = XOR of ADDR, LEN and all payload bytes.
REQ-019 States IDLE, ADDR, LEN, PAYLOAD, CHK, DRAIN; registered, one byte consumed per event.
REQ-020 IDLE: byte == SOF -> ADDR; other bytes and parity errors ignored silently.
REQ-021 ADDR: store byte -> LEN; LEN: 1..MAX_LEN -> store, PAYLOAD; 0 or >MAX_LEN -> err, code 2, IDLE.
REQ-022 PAYLOAD: write byte to internal buffer index 0..LEN-1; after LEN-th byte -> CHK.
REQ-023 CHK: match -> DRAIN, first wr_vld in next cycle; mismatch -> err, code 3, IDLE, no beats issued.
REQ-024 Parity error in ADDR/LEN/PAYLOAD/CHK: err, code 1, IDLE; frame discarded.
REQ-025 DRAIN: beat k (0..LEN-1) wr_addr = ADDR+k mod 256, wr_data = buffer[k]; wr_last on k == LEN-1.
REQ-026 wr_vld/wr_addr/wr_data/wr_last SHALL stay stable until accepted; one beat per cycle maximum.
REQ-027 Acceptance of last beat: frame_ok pulse same cycle as state -> IDLE registered; wr_vld low next cycle.
REQ-028 Byte event in DRAIN: byte dropped, err, code 5; drain continues unaffected.
REQ-029 err_code values: 1 parity, 2 length, 3 checksum, 4 timeout, 5 overrun; 0 after reset.

Reset
REQ-030 RST high at a rising edge: state IDLE, buffer index 0, timer 0; mid-frame or mid-drain abandoned, no err.
REQ-031 Reset values: wr_vld 0, wr_addr 0, wr_data 0, wr_last 0, busy 0, err 0, err_code 0, frame_ok 0.

Configuration
REQ-032 Macro UART_FRAME_TIMEOUT_EN defined: timer clears on each byte event, counts in ADDR/LEN/PAYLOAD/CHK; reaching TIMEOUT -> err, code 4, IDLE.
REQ-033 Macro undefined: no timer logic; a stalled frame waits indefinitely; code 4 never produced.

Verification
REQ-034 Bytes A5,10,02,11,22,21 (chk=10^02^11^22), wr_rdy=1 -> beats (10,11),(11,22,last), frame_ok once.
REQ-035 Same frame, CHK=00 -> err, err_code=3, no wr_vld; then valid frame -> normal beats.
REQ-036 A5,10,00 then A5,10,11 (MAX_LEN=16) -> err code 2 twice, busy low after each.
REQ-037 Valid 3-byte frame, wr_rdy low 5 cycles then high -> wr_vld held, data stable, 3 beats, addresses wrap FF->00 for ADDR=FE.
REQ-038 A5, rx_par_err during PAYLOAD -> err code 1; with UART_FRAME_TIMEOUT_EN, A5 then silence -> err code 4 at TIMEOUT clocks.
